// File: rtl/snn_pkg.sv
// Shared constants, types and the fixed bias table for the 16-neuron LIF spiking core.
package snn_pkg;

  localparam int unsigned NUM_NEURONS = 16;
  localparam int unsigned ADDR_W      = $clog2(NUM_NEURONS);
  localparam int unsigned V_WIDTH     = 8;
  localparam int unsigned THRESHOLD   = 100;
  localparam int unsigned LEAK_SHIFT  = 3;
  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned FIFO_PTR_W  = $clog2(FIFO_DEPTH);

  typedef logic [ADDR_W-1:0]  neuron_addr_t;
  typedef logic [V_WIDTH-1:0] potential_t;

  // Each neuron's bias current equals its own address.
  function automatic potential_t bias(neuron_addr_t addr);
    return potential_t'(addr);
  endfunction

endpackage

// File: rtl/snn_event_fifo.sv
// First-word fall-through spike event FIFO; a push into a full FIFO only lands if a pop
// frees a slot at the same edge.
module snn_event_fifo
  import snn_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_data,
  input  logic              pop,
  output logic              empty,
  output logic [ADDR_W-1:0] head
);

  neuron_addr_t            mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_W:0]     count_q, count_d;
  logic                    full;
  logic                    pop_ok;
  logic                    push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (FIFO_PTR_W+1)'(FIFO_DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full with a coincident pop, the write slot is the slot being vacated.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/snn_top.sv
// Time-multiplexed LIF core: one neuron per clock, spikes queued as addresses for the host.
module snn_top
  import snn_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              snn_ren,
  output logic              snn_event_n,
  output logic [ADDR_W-1:0] neuron_addr_out
);

  localparam neuron_addr_t LastIdx = neuron_addr_t'(NUM_NEURONS - 1);

  neuron_addr_t     idx_q;
  potential_t       v_q [NUM_NEURONS];
  potential_t       v_cur;
  potential_t       v_sat;
  potential_t       v_next;
  logic [V_WIDTH:0] v_sum;
  logic             spike;
  logic             fifo_empty;

  // One extra bit catches overflow of leak-plus-bias before saturating.
  always_comb begin
    v_cur  = v_q[idx_q];
    v_sum  = {1'b0, v_cur} - {1'b0, (v_cur >> LEAK_SHIFT)} + {1'b0, bias(idx_q)};
    v_sat  = v_sum[V_WIDTH] ? '1 : v_sum[V_WIDTH-1:0];
    spike  = (v_sum >= (V_WIDTH+1)'(THRESHOLD));
    v_next = spike ? '0 : v_sat;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) v_q[i] <= '0;
    end else begin
      idx_q        <= (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
      v_q[idx_q]   <= v_next;
    end
  end

  snn_event_fifo u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (spike),
    .push_data (idx_q),
    .pop       (snn_ren),
    .empty     (fifo_empty),
    .head      (neuron_addr_out)
  );

  assign snn_event_n = fifo_empty;

endmodule

// File: tb/tb_snn_top.sv
// Self-checking bench for snn_top against a queue-based behavioural model of the LIF core.
module tb_snn_top;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       snn_ren;
  logic       snn_event_n;
  logic [3:0] neuron_addr_out;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int mv [16];
  int midx;
  int mq [$];
  int edge_cnt;
  int first_spike_edge;
  int first_spike_addr;
  int popped [$];
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  snn_top dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .snn_ren         (snn_ren),
    .snn_event_n     (snn_event_n),
    .neuron_addr_out (neuron_addr_out)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mv[i] = 0;
    midx = 0;
    mq.delete();
    edge_cnt = 0;
    first_spike_edge = -1;
    first_spike_addr = -1;
  endtask

  function automatic int lif_next(input int v, input int n);
    int vn;
    vn = v - (v >> 3) + n;
    if (vn > 255) vn = 255;
    return vn;
  endfunction

  function automatic bit model_spike_next();
    return lif_next(mv[midx], midx) >= 100;
  endfunction

  task automatic model_step(input bit ren);
    int  vn;
    bit  spk;
    edge_cnt++;
    vn  = lif_next(mv[midx], midx);
    spk = (vn >= 100);
    mv[midx] = spk ? 0 : vn;
    if (ren && mq.size() > 0) void'(mq.pop_front());
    if (spk) begin
      if (first_spike_edge < 0) begin
        first_spike_edge = edge_cnt;
        first_spike_addr = midx;
      end
      if (mq.size() < 8) mq.push_back(midx);
    end
    midx = (midx + 1) % 16;
  endtask

  // One clock: drive at the falling edge, model follows the rising edge, return at next fall.
  task automatic tick(input bit ren);
    snn_ren = ren;
    if (ren && !snn_event_n) popped.push_back(int'(neuron_addr_out));
    @(posedge clock);
    if (reset_n) model_step(ren);
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("event_n", int'(snn_event_n), (mq.size() == 0) ? 1 : 0);
      check("head", int'(neuron_addr_out), (mq.size() != 0) ? mq[0] : 0);
    end
  end

  initial begin
    int exp_first [8];
    int exp_order [5];
    int budget;
    int combo_addr;
    bit found;

    exp_order = '{15, 14, 13, 15, 14};
    exp_first = '{15, 14, 13, 15, 14, 15, 13, 14};

    reset_n = 1'b0;
    snn_ren = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (5) @(negedge clock);
    check("rst_event_n", int'(snn_event_n), 1);
    check("rst_addr", int'(neuron_addr_out), 0);
    reset_n = 1'b1;

    // Popping an empty FIFO must do nothing.
    repeat (20) tick(1'b1);
    check("empty_pop_event_n", int'(snn_event_n), 1);
    check("empty_pop_addr", int'(neuron_addr_out), 0);

    // Spike order, popping each event as it appears.
    popped.delete();
    budget = 0;
    while (popped.size() < 5 && budget < 2000) begin
      tick(!snn_event_n);
      budget++;
    end
    check("order_budget", (popped.size() >= 5) ? 1 : 0, 1);
    for (int i = 0; i < 5; i++)
      if (i < popped.size()) check($sformatf("order[%0d]", i), popped[i], exp_order[i]);
    check("model_first_edge", first_spike_edge, 208);
    check("model_first_addr", first_spike_addr, 15);

    // Quiet neurons: 1000 cycles popping every event.
    popped.delete();
    repeat (1000) tick(!snn_event_n);
    check("quiet_events_seen", (popped.size() > 0) ? 1 : 0, 1);
    foreach (popped[i]) check("quiet_addr_ge13", (popped[i] >= 13) ? 1 : 0, 1);

    // Mid-run asynchronous reset with the FIFO non-empty.
    budget = 0;
    while (snn_event_n && budget < 400) begin
      tick(1'b0);
      budget++;
    end
    check("pre_reset_nonempty", int'(snn_event_n), 0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_event_n", int'(snn_event_n), 1);
    check("async_rst_addr", int'(neuron_addr_out), 0);
    @(negedge clock);
    tick(1'b0);
    tick(1'b0);
    reset_n = 1'b1;

    // Overflow: no pops for 2000 cycles, then the first 8 spikes come out in order.
    repeat (2000) tick(1'b0);
    check("ovf_event_n", int'(snn_event_n), 0);
    check("model_ovf_size", mq.size(), 8);
    popped.delete();
    repeat (8) tick(1'b1);
    check("ovf_pop_count", popped.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < popped.size()) check($sformatf("ovf[%0d]", i), popped[i], exp_first[i]);
    check("ovf_drained_event_n", int'(snn_event_n), 1);

    // Full FIFO with a spike coinciding with a pop.
    found = 1'b0;
    combo_addr = -1;
    budget = 0;
    while (!found && budget < 3000) begin
      if (mq.size() == 8 && model_spike_next()) begin
        combo_addr = midx;
        tick(1'b1);
        found = 1'b1;
      end else begin
        tick(1'b0);
      end
      budget++;
    end
    check("combo_found", int'(found), 1);
    check("combo_event_n", int'(snn_event_n), 0);
    check("combo_model_size", mq.size(), 8);
    popped.delete();
    repeat (8) tick(1'b1);
    check("combo_pop_count", popped.size(), 8);
    if (popped.size() == 8) check("combo_tail", popped[7], combo_addr);

    // Random host behaviour, including long no-pop bursts.
    for (int i = 0; i < 3000; i++) begin
      if ((i / 500) % 2 == 1) tick(($urandom % 16) == 0);
      else tick(($urandom % 4) != 0);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
